rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin arbiter that drives the select of the 4:1 channel mux.
//  - Takes four request lines and grants one channel at a time.
//  - Drives the mux select and a one-hot grant back to the requesters.
//  - Bounds each grant to HOLD_MAX cycles so no channel starves.
// PARAMETERS
//  HOLD_MAX  8                    max consecutive cycles one grant is held (>=1)
//  CNT_W     $clog2(HOLD_MAX+1)   width of hold counter (localparam, derived)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active-high
//  req          in   4      per-channel request, level; bit i = channel i
//  sel          out  2      mux select, registered; binary index of granted channel
//  grant        out  4      one-hot grant, registered; all-zero when idle
//  grant_valid  out  1      high while any grant is active (== |grant)
// BEHAVIOUR
//  Reset (rst high at posedge): outputs sel=0, grant=0, grant_valid=0.
//   Internal state: state=IDLE, last=3 (so ch0 has first priority), cnt=0.
//   rst dominates all other inputs, including in mid-grant.
//  Priority search: first i with req[i]=1, scanning last+1, last+2, ... mod 4 (wraps 3->0).
//   The scan includes last itself as the final candidate.
//  States:
//   IDLE: req==0 -> stay; grant=0, valid=0; sel holds its previous value (mux output stays stable).
//    req!=0 -> pick winner w. Next edge: grant=1<<w, sel=w, valid=1, cnt=1, state=BUSY.
//   BUSY (granted channel g=sel):
//    hold:    req[g]=1 and cnt<HOLD_MAX -> keep grant, cnt++.
//    release: req[g]=0, or cnt==HOLD_MAX -> last=g, then re-arbitrate on the same edge.
//     any req -> new winner granted at next edge, cnt=1, no idle bubble.
//     req==0  -> grant=0, valid=0, state=IDLE; sel keeps g.
//    At timeout with g the sole requester, g is re-granted.
//     grant and valid stay high, cnt restarts at 1.
//  Latency: a req sampled at edge N is visible on grant/sel after edge N (1 cycle).
//   A req drop at edge N is reflected after edge N.
//  Invariants:
//   - grant is one-hot or zero.
//   - grant!=0 implies grant==1<<sel.
//   - grant_valid==|grant.
//   - cnt never exceeds HOLD_MAX.
//  Simultaneous events:
//   - Drop of req[g] coinciding with cnt==HOLD_MAX is a single release, same result.
//   - Requests that appear during BUSY only take effect at release.
//  HOLD_MAX=1: grant rotates every cycle among active requesters.
// TESTING
//  1 Reset: rst=1 for 2 cycles, req=4'b1111 -> grant=0, valid=0, sel=0.
//    Then rst=0 -> after the 1st edge grant=4'b0001, sel=0.
//  2 Single req: req=4'b0100 -> next cycle grant=4'b0100, sel=2'b10, valid=1.
//    Drop req -> next cycle grant=0, valid=0, sel stays 2'b10.
//  3 Full load: req=4'b1111 held, HOLD_MAX=8 -> ch0, ch1, ch2, ch3, ch0 for 8 cycles each.
//    No cycle with valid=0 at any handoff.
//  4 Wrap: ch3 granted then released, req=4'b1001 -> next grant ch0 (sel=0), not ch3.
//  5 Sole requester: req=4'b0010 constant for 20 cycles -> grant=4'b0010 throughout.
//    valid never drops; cnt returns to 1 after 8.
//  6 Reset mid-grant: ch2 granted with cnt=5, rst=1 one cycle -> next cycle grant=0, sel=0.
//    With req=4'b1111 afterwards, ch0 is granted first.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a 4:1 channel mux: registered one-hot grant, binary select,
// and a bounded hold time per grant so that no requester starves.
module rr_mux_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       grant_valid
);

    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [1:0]       last, last_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       sel_n;
    logic [3:0]       grant_n;
    logic             valid_n;

    // Scan from+1, from+2, ... and finish on 'from' itself, so a lone holder can win again.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] from);
        logic [1:0] idx;
        logic [1:0] w;
        logic       found;
        w     = from;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = from + 2'(i);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 2'd3;
            cnt         <= '0;
            sel         <= 2'd0;
            grant       <= 4'b0000;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            last        <= last_n;
            cnt         <= cnt_n;
            sel         <= sel_n;
            grant       <= grant_n;
            grant_valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        sel_n   = sel;
        grant_n = grant;
        valid_n = grant_valid;

        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_n   = pick(req, last);
                    grant_n = 4'b0001 << pick(req, last);
                    valid_n = 1'b1;
                    cnt_n   = CNT_W'(1);
                    state_n = BUSY;
                end else begin
                    grant_n = 4'b0000;
                    valid_n = 1'b0;
                end
            end
            BUSY: begin
                if (req[sel] && (cnt < HOLD_C)) begin
                    cnt_n = cnt + CNT_W'(1);
                end else begin
                    // Release and re-arbitrate on the same edge to avoid an idle bubble.
                    last_n = sel;
                    if (req != 4'b0000) begin
                        sel_n   = pick(req, sel);
                        grant_n = 4'b0001 << pick(req, sel);
                        valid_n = 1'b1;
                        cnt_n   = CNT_W'(1);
                    end else begin
                        grant_n = 4'b0000;
                        valid_n = 1'b0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: the driver queues the expected outputs for each
// edge, and a separate monitor pops and compares them just after that edge.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       grant_valid;

    int checks   = 0;
    int failures = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];
    logic       drive_done = 1'b0;

    rr_mux_arbiter #(.HOLD_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .sel        (sel),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs and queue what the outputs must be after that edge.
    task automatic step(input string tag, input logic r, input logic [3:0] q,
                        input logic [3:0] eg, input logic [1:0] es);
        @(negedge clk);
        rst = r;
        req = q;
        exp_q.push_back({eg, es, |eg});
        tag_q.push_back(tag);
    endtask

    function automatic logic [3:0] onehot(input int ch);
        logic [3:0] v;
        v = 4'b0001 << ch;
        return v;
    endfunction

    initial begin : monitor
        logic [6:0] e;
        string      t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (grant !== e[6:3] || sel !== e[2:1] || grant_valid !== e[0]) begin
                    failures++;
                    $display("FAIL %s: got grant=%b sel=%0d valid=%b, want grant=%b sel=%0d valid=%b",
                             t, grant, sel, grant_valid, e[6:3], e[2:1], e[0]);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        req = 4'b0000;

        // Reset holds outputs low even with every channel requesting.
        step("reset0", 1'b1, 4'b1111, 4'b0000, 2'd0);
        step("reset1", 1'b1, 4'b1111, 4'b0000, 2'd0);
        step("post_reset_ch0", 1'b0, 4'b1111, 4'b0001, 2'd0);

        // Single requester, then drop: sel keeps 2 while idle.
        step("rst_a", 1'b1, 4'b0000, 4'b0000, 2'd0);
        step("single_ch2", 1'b0, 4'b0100, 4'b0100, 2'd2);
        step("drop_ch2", 1'b0, 4'b0000, 4'b0000, 2'd2);
        step("idle_sel_hold", 1'b0, 4'b0000, 4'b0000, 2'd2);

        // Full load: 8 cycles each, rotating 0,1,2,3,0 with no gap.
        step("rst_b", 1'b1, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 40; k++)
            step("full_load", 1'b0, 4'b1111, onehot((k / 8) % 4), 2'((k / 8) % 4));

        // Wrap: ch3 times out, then 1001 goes to ch0.
        step("rst_c", 1'b1, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 8; k++)
            step("ch3_hold", 1'b0, 4'b1000, 4'b1000, 2'd3);
        step("wrap_to_ch0", 1'b0, 4'b1001, 4'b0001, 2'd0);
        step("ch0_hold", 1'b0, 4'b1001, 4'b0001, 2'd0);

        // Sole requester is re-granted at every timeout without a gap.
        step("rst_d", 1'b1, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 20; k++)
            step("sole_ch1", 1'b0, 4'b0010, 4'b0010, 2'd1);

        // Drop coinciding with timeout is a single release.
        step("rst_e", 1'b1, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 8; k++)
            step("ch0_run", 1'b0, 4'b0011, 4'b0001, 2'd0);
        step("drop_at_timeout", 1'b0, 4'b0010, 4'b0010, 2'd1);

        // Late request does not preempt; reset mid-grant restarts from ch0.
        step("rst_f", 1'b1, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 5; k++)
            step("ch2_run", 1'b0, (k < 3) ? 4'b0100 : 4'b0101, 4'b0100, 2'd2);
        step("rst_mid_grant", 1'b1, 4'b1111, 4'b0000, 2'd0);
        step("after_rst_ch0", 1'b0, 4'b1111, 4'b0001, 2'd0);
        step("after_rst_hold", 1'b0, 4'b1111, 4'b0001, 2'd0);

        drive_done = 1'b1;
    end

    initial begin : finisher
        int waited;
        wait (drive_done);
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
